// File: rtl/kamacore_wb_scheduler.sv
// Write-back scheduler for the kamacore register file: round-robin arbitration of two
// result producers onto the single registered write port, plus a per-register busy scoreboard.
module kamacore_wb_scheduler #(
    parameter int unsigned CPU_WIDTH      = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter bit          DROP_ZERO      = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            issue_valid,
    output logic                            issue_ready,
    input  logic [REG_ADDR_WIDTH-1:0]       issue_rd_a,
    input  logic [REG_ADDR_WIDTH-1:0]       issue_rs1_a,
    input  logic [REG_ADDR_WIDTH-1:0]       issue_rs2_a,
    output logic                            issue_hazard,

    input  logic                            req0_valid,
    output logic                            req0_ready,
    input  logic [REG_ADDR_WIDTH-1:0]       req0_rd_a,
    input  logic [CPU_WIDTH-1:0]            req0_rd_data,

    input  logic                            req1_valid,
    output logic                            req1_ready,
    input  logic [REG_ADDR_WIDTH-1:0]       req1_rd_a,
    input  logic [CPU_WIDTH-1:0]            req1_rd_data,

    output logic                            rd_we,
    output logic [REG_ADDR_WIDTH-1:0]       rd_a,
    output logic [CPU_WIDTH-1:0]            rd_data,
    output logic [(2**REG_ADDR_WIDTH)-1:0]  busy
);

    localparam int unsigned REGISTER_COUNT = 2**REG_ADDR_WIDTH;

    logic                      r_last_grant;
    logic                      r_rd_we;
    logic [REG_ADDR_WIDTH-1:0] r_rd_a;
    logic [CPU_WIDTH-1:0]      r_rd_data;
    logic [REGISTER_COUNT-1:0] r_busy;

    logic                      w_grant0;
    logic                      w_grant1;
    logic                      w_accept;
    logic [REG_ADDR_WIDTH-1:0] w_sel_a;
    logic [CPU_WIDTH-1:0]      w_sel_data;
    logic                      w_we_next;
    logic                      w_issue_ready;
    logic                      w_rs1_haz;
    logic                      w_rs2_haz;
    logic [REGISTER_COUNT-1:0] w_set;
    logic [REGISTER_COUNT-1:0] w_clear;

    // Round-robin grant: a lone requester always wins, a tie goes to the one not served last.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!rst) begin
            if (req0_valid && (!req1_valid || r_last_grant)) begin
                w_grant0 = 1'b1;
            end else if (req1_valid) begin
                w_grant1 = 1'b1;
            end
        end
    end

    assign w_accept   = w_grant0 || w_grant1;
    assign w_sel_a    = w_grant1 ? req1_rd_a    : req0_rd_a;
    assign w_sel_data = w_grant1 ? req1_rd_data : req0_rd_data;
    assign w_we_next  = w_accept && !(DROP_ZERO && (w_sel_a == '0));

    // A write landing on the claimed register this cycle frees it for a new claim.
    assign w_issue_ready = !rst &&
                           (!r_busy[issue_rd_a] || (r_rd_we && (r_rd_a == issue_rd_a)));

    // Sources being written this cycle are served by the register file bypass.
    assign w_rs1_haz = r_busy[issue_rs1_a] &&
                       !(r_rd_we && (r_rd_a == issue_rs1_a)) &&
                       !(DROP_ZERO && (issue_rs1_a == '0));
    assign w_rs2_haz = r_busy[issue_rs2_a] &&
                       !(r_rd_we && (r_rd_a == issue_rs2_a)) &&
                       !(DROP_ZERO && (issue_rs2_a == '0));

    always_comb begin
        w_set = '0;
        if (issue_valid && w_issue_ready && !(DROP_ZERO && (issue_rd_a == '0))) begin
            w_set[issue_rd_a] = 1'b1;
        end
    end

    always_comb begin
        w_clear = '0;
        if (r_rd_we) begin
            w_clear[r_rd_a] = 1'b1;
        end
    end

    // Output write port; address and data hold when nothing is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_we      <= 1'b0;
            r_rd_a       <= '0;
            r_rd_data    <= '0;
            r_last_grant <= 1'b1;
        end else begin
            r_rd_we <= w_we_next;
            if (w_accept) begin
                r_rd_a       <= w_sel_a;
                r_rd_data    <= w_sel_data;
                r_last_grant <= w_grant1;
            end
        end
    end

    // Set is applied after clear so a same-cycle re-claim keeps the register busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clear) | w_set;
        end
    end

    assign req0_ready   = w_grant0;
    assign req1_ready   = w_grant1;
    assign issue_ready  = w_issue_ready;
    assign issue_hazard = w_rs1_haz || w_rs2_haz;
    assign rd_we        = r_rd_we;
    assign rd_a         = r_rd_a;
    assign rd_data      = r_rd_data;
    assign busy         = r_busy;

    a_one_ready : assert property (@(posedge clk) !(req0_ready && req1_ready));
    a_zero_idle : assert property (@(posedge clk) !(DROP_ZERO && r_busy[0]));

endmodule

// File: doc/kamacore_wb_scheduler.md
# kamacore_wb_scheduler

Write-back scheduler and register scoreboard in front of the kamacore register file's single write port. Two producers arbitrate round-robin for that port: the execute unit (requester 0) and the load/memory unit (requester 1). The block drives the registered write (`rd_we`/`rd_a`/`rd_data`). It also tracks which architectural registers have a write outstanding, so issue logic can stall on RAW and WAW hazards.

## Interface
Parameters
- `CPU_WIDTH`, project package: data width of register contents.
- `REG_ADDR_WIDTH`, project package: register index width; `REGISTER_COUNT = 2**REG_ADDR_WIDTH`.
- `DROP_ZERO`, default 1: when 1, register 0 is never written and never marked busy.

Ports
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `issue_valid`  in  1  issue stage claims a destination register.
- `issue_ready`  out  1  claim accepted this cycle.
- `issue_rd_a`  in  REG_ADDR_WIDTH  destination being claimed.
- `issue_rs1_a`, `issue_rs2_a`  in  REG_ADDR_WIDTH  source registers of the instruction at issue.
- `issue_hazard`  out  1  a source is busy and not bypassable this cycle.
- `req0_valid`, `req1_valid`  in  1  producer has a result.
- `req0_ready`, `req1_ready`  out  1  result accepted this cycle.
- `req0_rd_a`, `req1_rd_a`  in  REG_ADDR_WIDTH  result destination.
- `req0_rd_data`, `req1_rd_data`  in  CPU_WIDTH  result value.
- `rd_we`  out  1  to register file write enable (registered).
- `rd_a`  out  REG_ADDR_WIDTH  to register file write address (registered).
- `rd_data`  out  CPU_WIDTH  to register file write data (registered).
- `busy`  out  REGISTER_COUNT  scoreboard; bit i set means a write to register i is outstanding.

## Operation
- Arbitration:
  - State `last_grant` (1 bit).
  - If only reqN is valid, grant N.
  - If both are valid, grant the requester that is not `last_grant`.
  - `last_grant` updates only on an accepted handshake.
- `reqN_ready` = grant N, forced to 0 while `rst`; at most one ready per cycle. Ready does not depend on the output stage: the register file accepts every cycle, so throughput is one write per cycle.
- Accepted result (valid && ready) loads the output register next edge:
  - `rd_a` ← req rd_a and `rd_data` ← req data.
  - `rd_we` ← 1, except `rd_we` ← 0 when `DROP_ZERO` and `rd_a == 0`.
  - With no accept, `rd_we` ← 0; `rd_a`/`rd_data` hold.
- Scoreboard:
  - `busy[i]` sets on an issue handshake with `issue_rd_a == i` (not for i=0 when `DROP_ZERO`).
  - `busy[i]` clears at the end of any cycle with `rd_we && rd_a == i`.
  - Simultaneous set and clear of the same i: set wins (the new claim is younger).
- `issue_ready` = `!rst && !busy[issue_rd_a]`: a WAW stall while the prior write is outstanding. A register write to `issue_rd_a` in the same cycle counts as not busy, so the claim is accepted and set wins.
- `issue_hazard` (combinational): for each source s, `busy[s] && !(rd_we && rd_a == s)`, ORed over rs1 and rs2; register 0 never hazards when `DROP_ZERO`. This matches the register file's same-cycle write bypass.
- Results for registers not marked busy are legal and written normally; the scoreboard is unaffected.

## Timing
- Reset values: `rd_we`=0, `rd_a`=0, `rd_data`=0, `busy`=0, `last_grant`=1 (requester 0 wins the first tie), `req0_ready`/`req1_ready`/`issue_ready`=0 during `rst`.
- Latency:
  - Handshake at cycle T gives `rd_we`=1 at T+1.
  - Register file contents update at the T+1→T+2 edge; readers see the bypassed value during T+1.
  - Busy bit drops after T+1; `issue_hazard` for that register is low from T+1.
- Issue handshake at T sets `busy` visible at T+1.
- Asserting `rst` mid-operation clears all state at the next edge. A handshake presented in a reset cycle is not accepted (ready=0).
- Producers must hold valid/rd_a/rd_data stable until ready.

## Test plan
- Reset, then req0 alone writes r5=0xA5A5 → `req0_ready`=1 at T, `rd_we`=1, `rd_a`=5, `rd_data`=0xA5A5 at T+1, `rd_we`=0 at T+2.
- Both producers valid for 4 cycles (r1/r2) → grants alternate 0,1,0,1; `rd_a` sequence 1,2,1,2 with no gap cycles.
- Issue r7 at T → `busy[7]`=1 at T+1.
  - Issue r7 again → `issue_ready`=0 until the write-back.
  - Instruction with rs1=7 → `issue_hazard`=1 until the cycle `rd_we && rd_a==7`, where it is 0.
- Write-back of r7 and issue of r7 in the same cycle → `issue_ready`=1 and `busy[7]` stays 1 afterward.
- `DROP_ZERO`=1: issue r0 → `busy`=0; req1 writes r0 → `req1_ready`=1, `rd_we` stays 0; rs1=0 → `issue_hazard`=0.
- `rst` asserted while both producers are valid and `busy`=0x0F0 → readies 0 that cycle; next cycle `busy`=0 and `rd_we`=0, then req0 is granted first.
